// File: rtl/glyph_render_ctrl.sv
// Glyph ROM sweeper: reads an 8x16 1-bit glyph and streams (x, y, RGB565) pixels downstream.
// Build option TRANSPARENT_BG_EN drops background (zero) bits instead of emitting them.
module glyph_render_ctrl #(
    parameter int unsigned GW = 4,
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [GW-1:0] req_glyph,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [15:0]   req_fg,
    input  logic [15:0]   req_bg,
    output logic [GW-1:0] glyph_sel,
    output logic [6:0]    rom_addr,
    input  logic          rom_q,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [15:0]   pix_color,
    output logic          pix_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    // Buffer entry layout: {x, y, colour, last}
    localparam int unsigned PW = XW + YW + 17;

    logic [1:0]    st_q, st_d;
    logic [6:0]    addr_q;
    logic [GW-1:0] glyph_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [15:0]   fg_q, bg_q;
    logic          infl_q;
    logic [6:0]    infl_addr_q;
    logic [1:0]    cnt_q;
    logic [PW-1:0] buf0_q, buf1_q;

    logic          accept, issue, push, pop, keep, empty, last_raw;
    logic [2:0]    occ;
    logic [XW-1:0] new_x;
    logic [YW-1:0] new_y;
    logic [15:0]   new_c;
    logic          new_l;
    logic [PW-1:0] new_pix;

    assign empty     = (cnt_q == 2'd0) && !infl_q;
    assign done      = (st_q == StDrain) && empty;
    assign req_ready = (st_q == StIdle) || done;
    assign busy      = (st_q != StIdle) && !done;
    assign accept    = req_valid && req_ready;

    assign pix_valid = (cnt_q != 2'd0);
    assign pop       = pix_valid && pix_ready;

    // Credit the pixel leaving this cycle so a full pipeline keeps issuing without bubbles.
    assign occ   = {1'b0, cnt_q} + {2'b00, infl_q};
    assign issue = (st_q == StRun) && (occ < (3'd2 + {2'b00, pop}));

    assign new_x   = x_q + XW'(infl_addr_q[2:0]);
    assign new_y   = y_q + YW'(infl_addr_q[6:3]);
    assign new_c   = rom_q ? fg_q : bg_q;
`ifdef TRANSPARENT_BG_EN
    assign keep    = rom_q;
    assign new_l   = 1'b0;
`else
    assign keep    = 1'b1;
    assign new_l   = (infl_addr_q == 7'd127);
`endif
    assign new_pix = {new_x, new_y, new_c, new_l};
    assign push    = infl_q && keep;

    assign {pix_x, pix_y, pix_color, last_raw} = buf0_q;
    assign pix_last  = last_raw && pix_valid;
    assign rom_addr  = addr_q;
    assign glyph_sel = glyph_q;

    always_comb begin
        st_d = st_q;
        case (st_q)
            StIdle:  if (accept) st_d = StRun;
            StRun:   if (issue && (addr_q == 7'd127)) st_d = StDrain;
            StDrain: if (done) st_d = accept ? StRun : StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q        <= StIdle;
            addr_q      <= '0;
            glyph_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            st_q   <= st_d;
            infl_q <= issue;
            if (issue) infl_addr_q <= addr_q;
            if (accept) begin
                glyph_q <= req_glyph;
                x_q     <= req_x;
                y_q     <= req_y;
                fg_q    <= req_fg;
                bg_q    <= req_bg;
                addr_q  <= '0;
            end else if (issue) begin
                addr_q  <= addr_q + 7'd1;
            end
        end
    end

    // Two-entry output FIFO; head (buf0) only changes on pop or when empty, so pix_* hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else if (push && pop) begin
            if (cnt_q == 2'd2) begin
                buf0_q <= buf1_q;
                buf1_q <= new_pix;
            end else begin
                buf0_q <= new_pix;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) buf0_q <= new_pix;
            else               buf1_q <= new_pix;
            cnt_q <= cnt_q + 2'd1;
        end else if (pop) begin
            buf0_q <= buf1_q;
            cnt_q  <= cnt_q - 2'd1;
        end
    end

endmodule

// File: tb/tb_glyph_render_ctrl.sv
// Directed bench for glyph_render_ctrl with a behavioural registered glyph ROM.
module tb_glyph_render_ctrl;

    localparam int unsigned GW = 4;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 9;
`ifdef TRANSPARENT_BG_EN
    localparam int DoneLat = 129;
`else
    localparam int DoneLat = 130;
`endif

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   c;
        logic          l;
    } pix_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [GW-1:0] req_glyph = '0;
    logic [XW-1:0] req_x = '0;
    logic [YW-1:0] req_y = '0;
    logic [15:0]   req_fg = '0;
    logic [15:0]   req_bg = '0;
    logic [GW-1:0] glyph_sel;
    logic [6:0]    rom_addr;
    logic          rom_q;
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   pix_color;
    logic          pix_last;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    glyph_render_ctrl #(.GW(GW), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_glyph(req_glyph),
        .req_x(req_x), .req_y(req_y), .req_fg(req_fg), .req_bg(req_bg),
        .glyph_sel(glyph_sel), .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .pix_last(pix_last), .busy(busy), .done(done)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   hs_cyc = -1;
    int   first_cyc = -1;
    int   acc_cyc = 0;
    int   done_base = 0;
    logic rdy_rand = 1'b0;
    pix_t got[$];

    // Glyph 0: blank, glyph 1: rows 3..13 carry {row, ~row}, glyph 2: solid.
    function automatic logic [7:0] row_bits(input logic [GW-1:0] g, input logic [3:0] row);
        if (g == 4'd2) return 8'hFF;
        if (g == 4'd1 && row >= 4'd3 && row <= 4'd13) return {row, ~row};
        return 8'h00;
    endfunction

    function automatic logic gbit(input logic [GW-1:0] g, input logic [6:0] a);
        logic [7:0] rb;
        rb = row_bits(g, a[6:3]);
        return rb[a[2:0]];
    endfunction

    always @(posedge clock) rom_q <= gbit(glyph_sel, rom_addr);

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : mon
        pix_t cur;
        pix_t held;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            cyc++;
            cur = {pix_x, pix_y, pix_color, pix_last};
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check_eq("hold_stable", 64'({pix_valid, cur}), 64'({1'b1, held}));
                if (pix_valid && pix_ready) begin
                    got.push_back(cur);
                    hs_cyc = cyc;
                    if (first_cyc < 0) first_cyc = cyc;
                end
                if (done) begin
                    check_eq("done_without_pix", 64'(pix_valid), 64'(0));
                    done_cnt++;
                    done_cyc = cyc;
                end
                stall_prev = pix_valid && !pix_ready;
                held = cur;
            end
        end
    end

    task automatic do_req(input logic [GW-1:0] g, input logic [XW-1:0] x,
                          input logic [YW-1:0] y, input logic [15:0] fg, input logic [15:0] bg);
        int n = 0;
        req_glyph = g;
        req_x     = x;
        req_y     = y;
        req_fg    = fg;
        req_bg    = bg;
        req_valid = 1'b1;
        while (!req_ready && n < 500) begin
            tick();
            n++;
        end
        check_eq("req_accepted", 64'(req_ready), 64'(1));
        got.delete();
        first_cyc = -1;
        tick();
        done_base = done_cnt;
        acc_cyc   = cyc + 1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == done_base && n < 2000) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, 64'(done_cnt - done_base), 64'(1));
    endtask

    task automatic cmp_draw(input string tag, input logic [GW-1:0] g, input logic [XW-1:0] x,
                            input logic [YW-1:0] y, input logic [15:0] fg, input logic [15:0] bg);
        pix_t e[$];
        pix_t p;
        for (int i = 0; i < 128; i++) begin
            logic b;
            b   = gbit(g, 7'(i));
            p.x = x + XW'(i % 8);
            p.y = y + YW'(i / 8);
            p.c = b ? fg : bg;
            p.l = (i == 127);
`ifdef TRANSPARENT_BG_EN
            p.l = 1'b0;
            if (b) e.push_back(p);
`else
            e.push_back(p);
`endif
        end
        check_eq({tag, "_count"}, 64'(got.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check_eq($sformatf("%s_px%0d", tag, i), 64'(got[i]), 64'(e[i]));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int d0;
        tick(3);
        check_eq("rst_req_ready", 64'(req_ready), 64'(1));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_pix_valid", 64'(pix_valid), 64'(0));
        check_eq("rst_pix_last", 64'(pix_last), 64'(0));
        check_eq("rst_rom_addr", 64'(rom_addr), 64'(0));
        check_eq("rst_glyph_sel", 64'(glyph_sel), 64'(0));
        check_eq("rst_pix_data", 64'({pix_x, pix_y, pix_color}), 64'(0));
        reset = 1'b0;
        tick();

        // Basic draw, continuous ready
        do_req(4'd1, 9'd10, 9'd20, 16'hF800, 16'h0000);
        wait_done("t1");
        cmp_draw("t1", 4'd1, 9'd10, 9'd20, 16'hF800, 16'h0000);
        check_eq("t1_done_lat", 64'(done_cyc - acc_cyc), 64'(DoneLat));
`ifndef TRANSPARENT_BG_EN
        check_eq("t1_first_lat", 64'(first_cyc - acc_cyc), 64'(2));
        check_eq("t1_first_xy", 64'({got[0].x, got[0].y}), 64'({9'd10, 9'd20}));
        check_eq("t1_last_px", 64'({got[127].x, got[127].y, got[127].l}),
                 64'({9'd17, 9'd35, 1'b1}));
`endif

        // Same request with random backpressure
        rdy_rand = 1'b1;
        do_req(4'd1, 9'd10, 9'd20, 16'hF800, 16'h0000);
        wait_done("t2");
        rdy_rand = 1'b0;
        cmp_draw("t2", 4'd1, 9'd10, 9'd20, 16'hF800, 16'h0000);
`ifndef TRANSPARENT_BG_EN
        check_eq("t2_done_after_hs", 64'(done_cyc - hs_cyc), 64'(1));
`endif

        // Coordinate wrap
        do_req(4'd2, 9'd508, 9'd510, 16'h1234, 16'h5678);
        wait_done("t3");
        cmp_draw("t3", 4'd2, 9'd508, 9'd510, 16'h1234, 16'h5678);
        check_eq("t3_wrap_x", 64'(got[4].x), 64'(0));
        check_eq("t3_wrap_y", 64'(got[16].y), 64'(0));

        // Request while busy is held off until done
        do_req(4'd1, 9'd100, 9'd50, 16'hFFFF, 16'h0001);
        tick(3);
        req_glyph = 4'd2;
        req_x     = 9'd200;
        req_y     = 9'd60;
        req_fg    = 16'h07E0;
        req_bg    = 16'h001F;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            check_eq("t4_glyph_held", 64'(glyph_sel), 64'(1));
            check_eq("t4_busy", 64'(busy), 64'(1));
            tick();
            n++;
        end
        check_eq("t4_ready_at_done", 64'(done), 64'(1));
        cmp_draw("t4a", 4'd1, 9'd100, 9'd50, 16'hFFFF, 16'h0001);
        do_req(4'd2, 9'd200, 9'd60, 16'h07E0, 16'h001F);
        check_eq("t4_glyph_sel2", 64'(glyph_sel), 64'(2));
        wait_done("t4b");
        cmp_draw("t4b", 4'd2, 9'd200, 9'd60, 16'h07E0, 16'h001F);

        // Reset in the middle of a draw
        do_req(4'd2, 9'd10, 9'd20, 16'hF800, 16'h0000);
        n = 0;
        while (got.size() < 40 && n < 500) begin
            tick();
            n++;
        end
        check_eq("t5_reach40", 64'(got.size()), 64'(40));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t5_pix_valid", 64'(pix_valid), 64'(0));
        check_eq("t5_busy", 64'(busy), 64'(0));
        check_eq("t5_req_ready", 64'(req_ready), 64'(1));
        check_eq("t5_done", 64'(done), 64'(0));
        d0 = done_cnt;
        tick(200);
        check_eq("t5_no_done", 64'(done_cnt), 64'(d0));
        check_eq("t5_no_pix", 64'(got.size()), 64'(40));

        // Blank glyph: all background, or nothing at all when transparent
        do_req(4'd0, 9'd0, 9'd0, 16'hFFFF, 16'h0841);
        wait_done("t6");
        cmp_draw("t6", 4'd0, 9'd0, 9'd0, 16'hFFFF, 16'h0841);
        check_eq("t6_done_lat", 64'(done_cyc - acc_cyc), 64'(DoneLat));

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
